// File: rtl/alu_operand_skid_stage_pkg.sv
// -----------------------------------------------------------------------------
// alu_operand_skid_stage_pkg
// Shared definitions for the ALU operand skid stage: default operand/opcode
// widths and the occupancy state encoding (the encoding doubles as the
// occupancy count seen on the debug port).
// -----------------------------------------------------------------------------
package alu_operand_skid_stage_pkg;

    localparam int unsigned WIDTH_DEF = 16;
    localparam int unsigned OPW_DEF   = 4;

    // Encoding equals the number of held entries.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HALF  = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_t;

    // Width of one stored entry {X, Y, Op}.
    function automatic int unsigned entry_width(input int unsigned w, input int unsigned opw);
        return (2 * w) + opw;
    endfunction

endpackage

// File: rtl/alu_operand_skid_stage_reg.sv
// -----------------------------------------------------------------------------
// alu_operand_reg
// One operand entry register {X, Y, Op} with load enable and asynchronous
// active-high reset to zero. Used for both the MAIN and SKID slots.
// Ports:
//   Clk     in   clock, rising edge
//   Reset   in   asynchronous active-high reset
//   i_load  in   capture i_d on this edge
//   i_d     in   entry to capture
//   o_q     out  held entry
// -----------------------------------------------------------------------------
module alu_operand_reg #(
    parameter int unsigned W = 36
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         i_load,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    // Entry storage: cleared on reset, captured on load, otherwise held.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_q <= {W{1'b0}};
        end else if (i_load) begin
            r_q <= i_d;
        end else begin
            r_q <= r_q;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/alu_operand_skid_stage.sv
// -----------------------------------------------------------------------------
// alu_operand_skid_stage
// Two-entry valid/ready skid buffer in front of the 16-bit ALU. The MAIN slot
// drives the ALU operands; the SKID slot catches the one op that arrives while
// the ALU stalls. in_ready is decoded from the state register only, so there
// is no combinational path from out_ready to in_ready.
// Ports:
//   Clk, Reset           clock (rising) / asynchronous active-high reset
//   Flush                synchronous discard of all held entries
//   in_valid/in_ready    upstream handshake; in_X, in_Y, in_Op payload
//   out_valid/out_ready  ALU handshake; out_X, out_Y, out_Op payload
//   occupancy            number of held entries (0..2)
// -----------------------------------------------------------------------------
module alu_operand_skid_stage
    import alu_operand_skid_stage_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned OPW   = OPW_DEF
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_X,
    input  logic [WIDTH-1:0] in_Y,
    input  logic [OPW-1:0]   in_Op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_X,
    output logic [WIDTH-1:0] out_Y,
    output logic [OPW-1:0]   out_Op,
    output logic [1:0]       occupancy
);

    localparam int unsigned EW = entry_width(WIDTH, OPW);

    skid_state_t r_state;
    skid_state_t w_next_state;
    logic        w_in_fire;
    logic        w_out_fire;
    logic        w_main_load;
    logic        w_skid_load;
    logic [EW-1:0] w_in_entry;
    logic [EW-1:0] w_main_d;
    logic [EW-1:0] w_main_q;
    logic [EW-1:0] w_skid_q;

    assign in_ready   = (r_state != ST_FULL);
    assign out_valid  = (r_state != ST_EMPTY);
    assign occupancy  = r_state;
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;
    assign w_in_entry = {in_X, in_Y, in_Op};

    // MAIN refills from SKID when draining FULL, otherwise from the input.
    assign w_main_d = (r_state == ST_FULL) ? w_skid_q : w_in_entry;

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and slot load enables; Flush overrides every transition and
    // suppresses loads so a coincident input op is simply dropped.
    always_comb begin
        w_next_state = r_state;
        w_main_load  = 1'b0;
        w_skid_load  = 1'b0;
        if (Flush) begin
            w_next_state = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        w_main_load  = 1'b1;
                        w_next_state = ST_HALF;
                    end else begin
                        w_next_state = ST_EMPTY;
                    end
                end
                ST_HALF: begin
                    if (w_in_fire && w_out_fire) begin
                        w_main_load  = 1'b1;
                        w_next_state = ST_HALF;
                    end else if (w_in_fire) begin
                        w_skid_load  = 1'b1;
                        w_next_state = ST_FULL;
                    end else if (w_out_fire) begin
                        w_next_state = ST_EMPTY;
                    end else begin
                        w_next_state = ST_HALF;
                    end
                end
                ST_FULL: begin
                    if (w_out_fire) begin
                        w_main_load  = 1'b1;
                        w_next_state = ST_HALF;
                    end else begin
                        w_next_state = ST_FULL;
                    end
                end
                default: begin
                    w_next_state = ST_EMPTY;
                end
            endcase
        end
    end

    alu_operand_reg #(.W(EW)) u_main (
        .Clk    (Clk),
        .Reset  (Reset),
        .i_load (w_main_load),
        .i_d    (w_main_d),
        .o_q    (w_main_q)
    );

    alu_operand_reg #(.W(EW)) u_skid (
        .Clk    (Clk),
        .Reset  (Reset),
        .i_load (w_skid_load),
        .i_d    (w_in_entry),
        .o_q    (w_skid_q)
    );

    assign {out_X, out_Y, out_Op} = w_main_q;

endmodule

// File: tb/tb_alu_operand_skid_stage.sv
module tb_alu_operand_skid_stage;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_X;
    logic [15:0] in_Y;
    logic [3:0]  in_Op;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_X;
    logic [15:0] out_Y;
    logic [3:0]  out_Op;
    logic [1:0]  occupancy;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [3:0]  op;
    } entry_t;

    entry_t q[$];
    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    alu_operand_skid_stage dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Flush     (Flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_X      (in_X),
        .in_Y      (in_Y),
        .in_Op     (in_Op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_X     (out_X),
        .out_Y     (out_Y),
        .out_Op    (out_Op),
        .occupancy (occupancy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a two-deep FIFO; acceptance only when it has room.
    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            q.delete();
        end else begin
            automatic bit acc = in_valid && (q.size() < 2);
            automatic bit pop = (q.size() > 0) && out_ready;
            if (Flush) begin
                q.delete();
            end else begin
                if (pop) void'(q.pop_front());
                if (acc) q.push_back('{x: in_X, y: in_Y, op: in_Op});
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge Clk) begin
        if (!Reset) begin
            chk("occupancy", 32'(occupancy), 32'(q.size()));
            chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
            chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
            if (q.size() != 0) begin
                chk("out_X", 32'(out_X), 32'(q[0].x));
                chk("out_Y", 32'(out_Y), 32'(q[0].y));
                chk("out_Op", 32'(out_Op), 32'(q[0].op));
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    task automatic drive(input logic iv, input logic [15:0] x, input logic ordy, input logic fl);
        in_valid  = iv;
        in_X      = x;
        in_Y      = ~x;
        in_Op     = x[3:0];
        out_ready = ordy;
        Flush     = fl;
    endtask

    initial begin
        Reset = 1'b1;
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        repeat (2) tick();
        Reset = 1'b0;
        chk("post_reset_occ", 32'(occupancy), 32'd0);
        chk("post_reset_out_X", 32'(out_X), 32'h0);

        // Streaming
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 16'h00FF + 16'(i), 1'b1, 1'b0);
            tick();
            chk("stream_out_X", 32'(out_X), 32'(16'h00FF + 16'(i)));
            chk("stream_occ", 32'(occupancy), 32'd1);
            chk("stream_in_ready", 32'(in_ready), 32'd1);
        end
        drive(1'b0, 16'h0000, 1'b1, 1'b0);
        tick();
        chk("stream_drained", 32'(out_valid), 32'd0);

        // Backpressure
        drive(1'b1, 16'hAAAA, 1'b0, 1'b0);
        tick();
        chk("bp_half_X", 32'(out_X), 32'hAAAA);
        drive(1'b1, 16'h5555, 1'b0, 1'b0);
        tick();
        chk("bp_full_occ", 32'(occupancy), 32'd2);
        chk("bp_full_in_ready", 32'(in_ready), 32'd0);
        chk("bp_full_X", 32'(out_X), 32'hAAAA);
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        tick();
        chk("bp_hold_X", 32'(out_X), 32'hAAAA);
        chk("bp_hold_Y", 32'(out_Y), 32'h5555);
        drive(1'b0, 16'h0000, 1'b1, 1'b0);
        tick();
        chk("bp_release_X", 32'(out_X), 32'h5555);
        chk("bp_release_occ", 32'(occupancy), 32'd1);

        // Drain from FULL
        drive(1'b1, 16'h1111, 1'b0, 1'b0);
        tick();
        chk("drain_full_occ", 32'(occupancy), 32'd2);
        drive(1'b0, 16'h0000, 1'b1, 1'b0);
        tick();
        chk("drain_1_X", 32'(out_X), 32'h1111);
        tick();
        chk("drain_empty_occ", 32'(occupancy), 32'd0);
        chk("drain_empty_valid", 32'(out_valid), 32'd0);

        // Flush from FULL with a pending input
        drive(1'b1, 16'h2222, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'h3333, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'hDEAD, 1'b0, 1'b1);
        tick();
        chk("flush_full_valid", 32'(out_valid), 32'd0);
        chk("flush_full_occ", 32'(occupancy), 32'd0);
        chk("flush_full_in_ready", 32'(in_ready), 32'd1);
        // Flush from HALF with a coincident accepted input: that op is dropped
        drive(1'b1, 16'h4444, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'hBEEF, 1'b0, 1'b1);
        tick();
        chk("flush_half_occ", 32'(occupancy), 32'd0);
        drive(1'b0, 16'h0000, 1'b1, 1'b0);
        tick();
        chk("flush_dropped_occ", 32'(occupancy), 32'd0);
        drive(1'b1, 16'h1234, 1'b0, 1'b0);
        tick();
        chk("after_flush_X", 32'(out_X), 32'h1234);

        // Asynchronous reset between clock edges
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        #1;
        Reset = 1'b1;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_in_ready", 32'(in_ready), 32'd1);
        chk("async_rst_occ", 32'(occupancy), 32'd0);
        chk("async_rst_X", 32'(out_X), 32'h0);
        tick();
        Reset = 1'b0;

        // Random traffic, scoreboarded every cycle by the model
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)), 1'b0);
            tick();
        end

        // Bounded drain
        drive(1'b0, 16'h0000, 1'b1, 1'b0);
        for (int i = 0; i < 4 && occupancy != 2'd0; i++) tick();
        chk("final_drain_occ", 32'(occupancy), 32'd0);
        chk("final_model_empty", 32'(q.size()), 32'd0);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
